// File: rtl/xuly_chinh_truong_n_pkg.sv
// Shared constants and types for the hh:mm:ss set-mode controller.
//   MODE_RUN        gt_mod value meaning "not editing"
//   DEF_*           default geometry, field limits and timing
//   HOLD_W          width of the hold-tick threshold fed to the repeaters
//   blink_t         blink phase of the selected field
package xuly_chinh_truong_n_pkg;
  localparam int MODE_RUN       = 0;
  localparam int DEF_NUM_FIELD  = 3;
  localparam int DEF_FW         = 6;
  // Field 0 (hours) sits in the low bits.
  localparam logic [DEF_NUM_FIELD*DEF_FW-1:0] DEF_MODS = {6'd60, 6'd60, 6'd24};
  localparam int DEF_HOLD_TICKS = 2;
  localparam int DEF_TIMEOUT    = 20;
  localparam int HOLD_W         = 8;

  typedef enum logic {PH_OFF = 1'b0, PH_ON = 1'b1} blink_t;
endpackage

// File: rtl/xuly_chinh_truong_n_btn_repeat.sv
// Key step generator: one step on the key's rising edge, then one step per
// ena_rep tick once the key has been held for hold_ticks ena_hold ticks.
//   ckht, rst     clock, async active-low reset
//   key           debounced key level (already gated by the caller)
//   ena_hold      hold timebase tick
//   ena_rep       repeat-rate tick
//   hold_ticks    ticks of hold before repeat arms
//   step_p        step request, combinational, valid in the cycle it is high
module btn_repeat
  import xuly_chinh_truong_n_pkg::*;
#(
  parameter int HW = HOLD_W
) (
  input  logic          ckht,
  input  logic          rst,
  input  logic          key,
  input  logic          ena_hold,
  input  logic          ena_rep,
  input  logic [HW-1:0] hold_ticks,
  output logic          step_p
);
  logic          key_q;
  logic [HW-1:0] cnt;

  // cnt saturates at the threshold so it cannot wrap during a long hold.
  always_ff @(posedge ckht or negedge rst) begin
    if (!rst) begin
      key_q <= 1'b0;
      cnt   <= '0;
    end else begin
      key_q <= key;
      if (!key)                             cnt <= '0;
      else if (ena_hold && cnt < hold_ticks) cnt <= cnt + 1'b1;
    end
  end

  assign step_p = key & (~key_q | (ena_rep & (cnt >= hold_ticks)));
endmodule

// File: rtl/xuly_chinh_truong_n.sv
// Set-mode controller for an hh:mm:ss display. btn_mod walks
// RUN -> field 0 .. field N-1 -> RUN (commit); up/down keys step the selected
// field modulo its limit with hold-to-repeat; idle time abandons the edit.
//   ckht, rst         clock, async active-low reset
//   btn_mod           mode key pulse
//   cdb_up, cdb_dw    up/down key levels
//   ena2hz, ena_rep   2 Hz (blink/hold/timeout) and repeat-rate ticks
//   cur_val           live clock value, captured on edit entry
//   gt_mod            0 = RUN, k = editing field k-1
//   set_val, load_p   edited value and its 1-cycle commit strobe
//   dc_led, ena_led   per-digit decimal points and blink enables
module xuly_chinh_truong_n
  import xuly_chinh_truong_n_pkg::*;
#(
  parameter int                        NUM_FIELD  = DEF_NUM_FIELD,
  parameter int                        FW         = DEF_FW,
  parameter logic [NUM_FIELD*FW-1:0]   MODS       = DEF_MODS,
  parameter int                        HOLD_TICKS = DEF_HOLD_TICKS,
  parameter int                        TIMEOUT    = DEF_TIMEOUT,
  localparam int                       MW         = $clog2(NUM_FIELD + 1)
) (
  input  logic                    ckht,
  input  logic                    rst,
  input  logic                    btn_mod,
  input  logic                    cdb_up,
  input  logic                    cdb_dw,
  input  logic                    ena2hz,
  input  logic                    ena_rep,
  input  logic [NUM_FIELD*FW-1:0] cur_val,
  output logic [MW-1:0]           gt_mod,
  output logic [NUM_FIELD*FW-1:0] set_val,
  output logic                    load_p,
  output logic [2*NUM_FIELD-1:0]  dc_led,
  output logic [2*NUM_FIELD-1:0]  ena_led
);
  localparam int IW = $clog2(TIMEOUT + 1);

  logic                    up_q, dw_q, lock_q, lock_now;
  logic                    key_up, key_dw, up_p, dw_p, key_edge, to_hit;
  blink_t                  phase;
  logic [IW-1:0]           idle, nxt_idle;
  logic [MW-1:0]           nxt_mod;
  logic [NUM_FIELD*FW-1:0] nxt_val;
  logic                    nxt_load;

  function automatic logic [FW-1:0] step_field(input logic [FW-1:0] v,
                                               input logic [FW-1:0] m,
                                               input logic          up);
    if (up) return (v == m - 1'b1) ? '0 : v + 1'b1;
    return (v == '0) ? m - 1'b1 : v - 1'b1;
  endfunction

  // Both keys down locks out stepping until both are released; the lock is
  // applied combinationally so a simultaneous press never yields an edge.
  assign lock_now = lock_q | (cdb_up & cdb_dw);
  assign key_up   = cdb_up & ~lock_now;
  assign key_dw   = cdb_dw & ~lock_now;
  assign key_edge = (cdb_up ^ up_q) | (cdb_dw ^ dw_q);

  btn_repeat #(.HW(HOLD_W)) u_rep_up (
    .ckht(ckht), .rst(rst), .key(key_up), .ena_hold(ena2hz), .ena_rep(ena_rep),
    .hold_ticks(HOLD_W'(HOLD_TICKS)), .step_p(up_p));

  btn_repeat #(.HW(HOLD_W)) u_rep_dw (
    .ckht(ckht), .rst(rst), .key(key_dw), .ena_hold(ena2hz), .ena_rep(ena_rep),
    .hold_ticks(HOLD_W'(HOLD_TICKS)), .step_p(dw_p));

  always_ff @(posedge ckht or negedge rst) begin
    if (!rst) begin
      gt_mod  <= MW'(MODE_RUN);
      set_val <= '0;
      load_p  <= 1'b0;
      idle    <= '0;
      up_q    <= 1'b0;
      dw_q    <= 1'b0;
      lock_q  <= 1'b0;
      phase   <= PH_ON;
    end else begin
      gt_mod  <= nxt_mod;
      set_val <= nxt_val;
      load_p  <= nxt_load;
      idle    <= nxt_idle;
      up_q    <= cdb_up;
      dw_q    <= cdb_dw;
      if (cdb_up & cdb_dw)      lock_q <= 1'b1;
      else if (!cdb_up && !cdb_dw) lock_q <= 1'b0;
      // Holding a key pins the blink ON so the digit stays readable.
      if (cdb_up | cdb_dw) phase <= PH_ON;
      else if (ena2hz)     phase <= (phase == PH_ON) ? PH_OFF : PH_ON;
    end
  end

  always_comb begin
    nxt_mod  = gt_mod;
    nxt_val  = set_val;
    nxt_load = 1'b0;
    nxt_idle = idle;
    to_hit   = 1'b0;
    // btn_mod is ignored during the commit cycle so set_val stays stable.
    if (btn_mod && !load_p) begin
      nxt_idle = '0;
      if (gt_mod == MW'(MODE_RUN)) begin
        for (int i = 0; i < NUM_FIELD; i++)
          nxt_val[FW*i +: FW] = (cur_val[FW*i +: FW] >= MODS[FW*i +: FW]) ? '0 : cur_val[FW*i +: FW];
        nxt_mod = MW'(1);
      end else if (gt_mod == MW'(NUM_FIELD)) begin
        nxt_mod  = MW'(MODE_RUN);
        nxt_load = 1'b1;
      end else begin
        nxt_mod = gt_mod + 1'b1;
      end
    end else if (gt_mod != MW'(MODE_RUN)) begin
      if (key_edge) nxt_idle = '0;
      else if (ena2hz) begin
        if (idle == IW'(TIMEOUT - 1)) begin
          nxt_mod  = MW'(MODE_RUN);
          nxt_idle = '0;
          to_hit   = 1'b1;
        end else begin
          nxt_idle = idle + 1'b1;
        end
      end
      if (!to_hit && (up_p ^ dw_p))
        for (int i = 0; i < NUM_FIELD; i++)
          if (gt_mod == MW'(i + 1))
            nxt_val[FW*i +: FW] = step_field(set_val[FW*i +: FW], MODS[FW*i +: FW], up_p);
    end
  end

  always_comb begin
    dc_led  = '0;
    ena_led = '1;
    for (int i = 0; i < NUM_FIELD; i++)
      if (gt_mod == MW'(i + 1)) begin
        dc_led[2*i +: 2]  = 2'b11;
        ena_led[2*i +: 2] = {2{phase == PH_ON}};
      end
  end
endmodule

// File: tb/tb_xuly_chinh_truong_n.sv
module tb_xuly_chinh_truong_n;
  localparam int HOLD = 2;
  localparam int TO   = 20;
  int MOD [3] = '{24, 60, 60};

  logic        ckht = 1'b0, rst = 1'b0;
  logic        btn_mod = 1'b0, cdb_up = 1'b0, cdb_dw = 1'b0, ena2hz = 1'b0, ena_rep = 1'b0;
  logic [17:0] cur_val = '0;
  logic [1:0]  gt_mod;
  logic [17:0] set_val;
  logic        load_p;
  logic [5:0]  dc_led, ena_led;

  int n_chk = 0, n_fail = 0;

  // Behavioural model state (plain integers, modulo arithmetic).
  int m_mode, m_idle, m_hu, m_hd;
  int m_f [3];
  bit m_load, m_ph, m_upq, m_dwq, m_lock, m_kuq, m_kdq;

  xuly_chinh_truong_n dut (
    .ckht(ckht), .rst(rst), .btn_mod(btn_mod), .cdb_up(cdb_up), .cdb_dw(cdb_dw),
    .ena2hz(ena2hz), .ena_rep(ena_rep), .cur_val(cur_val), .gt_mod(gt_mod),
    .set_val(set_val), .load_p(load_p), .dc_led(dc_led), .ena_led(ena_led));

  always #5 ckht = ~ckht;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    assert (act === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_f(input string tag, input int idx, input int val);
    chk(tag, 32'(set_val[6*idx +: 6]), 32'(val));
  endtask

  task automatic model_reset();
    m_mode = 0; m_idle = 0; m_hu = 0; m_hd = 0;
    foreach (m_f[i]) m_f[i] = 0;
    m_load = 0; m_ph = 1; m_upq = 0; m_dwq = 0; m_lock = 0; m_kuq = 0; m_kdq = 0;
  endtask

  task automatic model_step();
    bit lk, ku, kd, su, sd, kedge, to;
    int nm, k;
    lk    = m_lock || (cdb_up && cdb_dw);
    ku    = cdb_up && !lk;
    kd    = cdb_dw && !lk;
    su    = ku && (!m_kuq || (ena_rep && m_hu >= HOLD));
    sd    = kd && (!m_kdq || (ena_rep && m_hd >= HOLD));
    kedge = (cdb_up != m_upq) || (cdb_dw != m_dwq);
    to = 0; nm = m_mode;
    if (btn_mod && !m_load) begin
      m_idle = 0;
      if (m_mode == 0) begin
        for (int i = 0; i < 3; i++)
          m_f[i] = (int'(cur_val[6*i +: 6]) >= MOD[i]) ? 0 : int'(cur_val[6*i +: 6]);
        nm = 1;
      end else nm = (m_mode == 3) ? 0 : m_mode + 1;
      m_load = (m_mode == 3);
    end else begin
      m_load = 0;
      if (m_mode != 0) begin
        if (kedge) m_idle = 0;
        else if (ena2hz) begin
          m_idle++;
          if (m_idle == TO) begin nm = 0; m_idle = 0; to = 1; end
        end
        if (!to && su != sd) begin
          k = m_mode - 1;
          m_f[k] = su ? (m_f[k] + 1) % MOD[k] : (m_f[k] + MOD[k] - 1) % MOD[k];
        end
      end
    end
    m_mode = nm;
    m_hu = ku ? m_hu + int'(ena2hz) : 0;
    m_hd = kd ? m_hd + int'(ena2hz) : 0;
    m_kuq = ku; m_kdq = kd;
    if (cdb_up && cdb_dw) m_lock = 1; else if (!cdb_up && !cdb_dw) m_lock = 0;
    m_ph = (cdb_up || cdb_dw) ? 1'b1 : (ena2hz ? !m_ph : m_ph);
    m_upq = cdb_up; m_dwq = cdb_dw;
  endtask

  task automatic check_model();
    logic [17:0] ev;
    logic [5:0]  ed, ee;
    ed = '0; ee = '1;
    for (int i = 0; i < 3; i++) begin
      ev[6*i +: 6] = 6'(m_f[i]);
      if (m_mode == i + 1) begin ed[2*i +: 2] = 2'b11; ee[2*i +: 2] = {2{m_ph}}; end
    end
    chk("gt_mod",  32'(gt_mod),  32'(m_mode));
    chk("set_val", 32'(set_val), 32'(ev));
    chk("load_p",  32'(load_p),  32'(m_load));
    chk("dc_led",  32'(dc_led),  32'(ed));
    chk("ena_led", 32'(ena_led), 32'(ee));
  endtask

  task automatic cyc(input bit b = 0, input bit e2 = 0, input bit er = 0);
    btn_mod = b; ena2hz = e2; ena_rep = er;
    @(posedge ckht);
    model_step();
    #1;
    btn_mod = 0; ena2hz = 0; ena_rep = 0;
    check_model();
  endtask

  task automatic tap_up();
    cdb_up = 1; cyc(); cdb_up = 0; cyc();
  endtask

  task automatic tap_dw();
    cdb_dw = 1; cyc(); cdb_dw = 0; cyc();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_gt"},  32'(gt_mod),  32'd0);
    chk({tag, "_val"}, 32'(set_val), 32'd0);
    chk({tag, "_ld"},  32'(load_p),  32'd0);
    chk({tag, "_dc"},  32'(dc_led),  32'd0);
    chk({tag, "_en"},  32'(ena_led), 32'h3f);
  endtask

  task automatic do_reset(input string tag);
    btn_mod = 0; cdb_up = 0; cdb_dw = 0; ena2hz = 0; ena_rep = 0;
    #2 rst = 0;
    #1 chk_reset(tag);
    model_reset();
    @(negedge ckht);
    rst = 1;
    #1;
  endtask

  initial begin
    model_reset();
    cur_val = {6'd0, 6'd59, 6'd23};
    #3 chk_reset("rst0");
    @(negedge ckht);
    rst = 1;
    #1;

    // 1: enter edit, hours wrap both ways
    cyc(1);
    chk("t1_mode", 32'(gt_mod), 32'd1);
    chk_f("t1_h", 0, 23); chk_f("t1_m", 1, 59); chk_f("t1_s", 2, 0);
    cdb_up = 1; cyc(); chk_f("t1_up_h", 0, 0);
    cdb_up = 0; cyc();
    cdb_dw = 1; cyc(); chk_f("t1_dw_h", 0, 23);
    cdb_dw = 0; cyc();

    // 2: minutes wrap
    cyc(1); chk("t2_mode", 32'(gt_mod), 32'd2);
    tap_up(); chk_f("t2_m0", 1, 0);
    tap_dw(); chk_f("t2_m59", 1, 59);
    tap_up(); chk_f("t2_m00", 1, 0);
    chk_f("t2_h", 0, 23); chk_f("t2_s", 2, 0);

    // 3: hold-to-repeat on seconds
    cyc(1); chk("t3_mode", 32'(gt_mod), 32'd3);
    for (int i = 0; i < 10; i++) tap_up();
    chk_f("t3_s10", 2, 10);
    cdb_up = 1; cyc(); chk_f("t3_edge", 2, 11);
    cyc(0, 0, 1); cyc(0, 1, 0); cyc(0, 0, 1);
    chk_f("t3_norep", 2, 11);
    cyc(0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1);
    chk_f("t3_rep", 2, 16);
    cdb_up = 0; cyc(0, 0, 1); cyc(0, 0, 1);
    chk_f("t3_stop", 2, 16);

    // 4: commit
    cyc(1);
    chk("t4_mode", 32'(gt_mod), 32'd0); chk("t4_ld1", 32'(load_p), 32'd1);
    chk("t4_val", 32'(set_val), 32'({6'd16, 6'd0, 6'd23}));
    cyc(); chk("t4_ld0", 32'(load_p), 32'd0);

    // 5: clamp on entry, idle timeout restarted by a key edge
    cur_val = {6'd56, 6'd61, 6'd30};
    cyc(1); chk("t5_clamp", 32'(set_val), 32'({6'd56, 6'd0, 6'd0}));
    cyc(1);
    for (int i = 0; i < 19; i++) cyc(0, 1, 0);
    chk("t5_t19", 32'(gt_mod), 32'd2);
    tap_up();
    for (int i = 0; i < 19; i++) cyc(0, 1, 0);
    chk("t5_still", 32'(gt_mod), 32'd2);
    cyc(0, 1, 0);
    chk("t5_to", 32'(gt_mod), 32'd0); chk("t5_nold", 32'(load_p), 32'd0);
    chk_f("t5_kept", 1, 1);

    // 6: both keys, mode+edge collision, async reset mid-edit
    cur_val = {6'd0, 6'd59, 6'd23};
    cyc(1);
    cdb_up = 1; cdb_dw = 1; cyc(); cyc(0, 1, 1);
    cdb_dw = 0; cyc(0, 1, 1); cyc(0, 0, 1);
    chk_f("t6_both", 0, 23);
    cdb_up = 0; cyc();
    cdb_up = 1; cyc(1);
    chk("t6_mode", 32'(gt_mod), 32'd2); chk_f("t6_h", 0, 23); chk_f("t6_m", 1, 59);
    cdb_up = 0; cyc();
    cdb_up = 1; cyc();
    do_reset("t6_rst");

    // Random traffic against the model, with one reset in the middle
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(7) == 0) cdb_up = ~cdb_up;
      if ($urandom_range(9) == 0) cdb_dw = ~cdb_dw;
      if ($urandom_range(15) == 0) cur_val = 18'($urandom);
      if (n == 400) do_reset("rnd_rst");
      cyc($urandom_range(11) == 0, $urandom_range(4) == 0, $urandom_range(2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
